// File: rtl/pixl_stream.sv
// Raster-order frame-buffer reader that presents pixels on a valid/ready stream with SOF/EOL/EOF flags.
// Optional PIXL_STREAM_LOOP_EN adds a `loop` input that chains frames back to back without a bubble.
module pixl_stream #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 1,
    parameter int RD_LAT    = 1,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef PIXL_STREAM_LOOP_EN
    input  logic              loop,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done
);
    localparam int D      = RD_LAT + 2;
    localparam int STAGES = RD_LAT - 1;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW     = $clog2(D);
    localparam int NW     = $clog2(D + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_H - 1);
    localparam logic [NW:0]   DEPTH     = (NW + 1)'(D);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } flags_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        flags_t            flags;
    } entry_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [CW-1:0]     col;
    logic [LW-1:0]     line;
    logic [STAGES:0]   vld_pipe;
    flags_t            flg_pipe [STAGES+1];
    entry_t            mem [D];
    entry_t            head;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [NW-1:0]     count, inflight;
    logic [NW:0]       outstanding;
    logic              pop, push, issue, last_issue, eof_hs, loop_en;
    flags_t            issue_flags;

`ifdef PIXL_STREAM_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int k = 0; k <= STAGES; k++) inflight = inflight + NW'(vld_pipe[k]);
    end

    // Credit counts reads in flight plus queued entries, net of this cycle's pop.
    assign outstanding = {1'b0, inflight} + {1'b0, count} - (NW + 1)'(pop);
    assign issue       = (state == ISSUE) && (outstanding < DEPTH);
    assign rd_en       = issue;
    assign rd_addr     = ADDR_W'(BASE_ADDR) + idx;

    assign issue_flags.sof = (col == '0) && (line == '0);
    assign issue_flags.eol = (col == COL_LAST);
    assign issue_flags.eof = issue_flags.eol && (line == LINE_LAST);
    assign last_issue      = issue && issue_flags.eof;

    assign head      = mem[rd_ptr];
    assign pix_valid = (count != '0);
    assign pix_data  = pix_valid ? head.data : '0;
    assign pix_sof   = pix_valid & head.flags.sof;
    assign pix_eol   = pix_valid & head.flags.eol;
    assign pix_eof   = pix_valid & head.flags.eof;
    assign pop       = pix_valid & pix_ready;
    assign push      = vld_pipe[STAGES];
    assign eof_hs    = pop & head.flags.eof;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int k = 0; k <= STAGES; k++) flg_pipe[k] <= '0;
        end else begin
            vld_pipe[0] <= issue;
            flg_pipe[0] <= issue_flags;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                flg_pipe[k] <= flg_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {rd_data, flg_pipe[STAGES]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + NW'(push) - NW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            col   <= '0;
            line  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= eof_hs;
            if (issue) begin
                idx <= last_issue ? '0 : idx + ADDR_W'(1);
                col <= issue_flags.eol ? '0 : col + CW'(1);
                if (issue_flags.eol) line <= issue_flags.eof ? '0 : line + LW'(1);
            end
            case (state)
                IDLE: if (start) begin
                    state <= ISSUE;
                    busy  <= 1'b1;
                end
                ISSUE: if (last_issue && !loop_en) state <= DRAIN;
                // Leave only on the final EOF, so an earlier looped frame's EOF still queued is not mistaken for it.
                DRAIN: if (eof_hs && inflight == '0 && count == NW'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixl_stream.sv
// Bench for pixl_stream: three instances (28x28 lat1, 4x3 lat3, 4x3 lat2) driven one at a time from a scenario table.
module tb_pixl_stream;
    logic clk = 1'b0;
    logic reset, start, pix_ready;
    int   sel;

    logic       start_v [3];
    logic       rd_en   [3];
    logic [9:0] rd_addr [3];
    logic [7:0] pdata   [3];
    logic       pvalid  [3];
    logic       psof    [3];
    logic       peol    [3];
    logic       peof    [3];
    logic       busy    [3];
    logic       done    [3];
    logic       pdata_a;
    logic [7:0] ram_a;
    logic [7:0] ram_b [3];
    logic [7:0] ram_c [2];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    typedef struct {
        int sel;
        int pct;
        int restart_at;
        int abort_at;
        int exp_pix;
        int exp_done;
        int exp_first;
        int exp_last;
    } vec_t;

    exp_t        q [$];
    vec_t        tbl [9];
    int          checks = 0, errors = 0;
    int          rel, npix, ndone, first_v, last_hs, outst, acnt;
    logic        stall_prev, prev_eof_hs;
    logic [10:0] held;

    function automatic logic [7:0] ram_f(input logic [9:0] a);
        logic [9:0] t;
        t = (a * 10'd37 + 10'd11) ^ (a >> 3);
        return t[7:0];
    endfunction

    function automatic int img_w(input int s);  return (s == 0) ? 28 : 4;   endfunction
    function automatic int img_n(input int s);  return (s == 0) ? 784 : 12; endfunction
    function automatic int base_of(input int s); return (s == 0) ? 0 : 100; endfunction
    function automatic int depth(input int s);  return (s == 0) ? 3 : ((s == 1) ? 5 : 4); endfunction

    assign start_v[0] = start & (sel == 0);
    assign start_v[1] = start & (sel == 1);
    assign start_v[2] = start & (sel == 2);
    assign pdata[0]   = {7'd0, pdata_a};

    always @(posedge clk) begin
        ram_a    <= ram_f(rd_addr[0]);
        ram_b[0] <= ram_f(rd_addr[1]);
        ram_b[1] <= ram_b[0];
        ram_b[2] <= ram_b[1];
        ram_c[0] <= ram_f(rd_addr[2]);
        ram_c[1] <= ram_c[0];
    end

    pixl_stream u_a (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(^ram_a),
        .pix_data(pdata_a), .pix_valid(pvalid[0]), .pix_ready(pix_ready),
        .pix_sof(psof[0]), .pix_eol(peol[0]), .pix_eof(peof[0]),
        .busy(busy[0]), .done(done[0])
    );

    pixl_stream #(.IMG_W(4), .IMG_H(3), .DATA_W(8), .RD_LAT(3), .BASE_ADDR(100)) u_b (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(ram_b[2]),
        .pix_data(pdata[1]), .pix_valid(pvalid[1]), .pix_ready(pix_ready),
        .pix_sof(psof[1]), .pix_eol(peol[1]), .pix_eof(peof[1]),
        .busy(busy[1]), .done(done[1])
    );

    pixl_stream #(.IMG_W(4), .IMG_H(3), .DATA_W(8), .RD_LAT(2), .BASE_ADDR(100)) u_c (
        .clk(clk), .reset(reset), .start(start_v[2]),
        .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(ram_c[1]),
        .pix_data(pdata[2]), .pix_valid(pvalid[2]), .pix_ready(pix_ready),
        .pix_sof(psof[2]), .pix_eol(peol[2]), .pix_eof(peof[2]),
        .busy(busy[2]), .done(done[2])
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input int s, input string tag);
        chk($sformatf("%s reset_values dut%0d", tag, s),
            64'({rd_en[s], rd_addr[s], pvalid[s], psof[s], peol[s], peof[s], pdata[s], busy[s], done[s]}),
            64'({1'b0, 10'(base_of(s)), 4'b0000, 8'h00, 2'b00}));
    endtask

    // Samples the active instance mid-cycle and scores every handshake against the queue.
    task automatic monitor();
        logic        hs;
        logic [10:0] cur;
        exp_t        e;
        hs  = pvalid[sel] & pix_ready;
        cur = {pdata[sel], psof[sel], peol[sel], peof[sel]};
        if (rd_en[sel]) begin
            chk($sformatf("rd_addr #%0d", acnt), 64'(rd_addr[sel]), 64'(base_of(sel) + acnt));
            acnt++;
            outst++;
        end
        if (hs) outst--;
        if (rd_en[sel]) begin
            checks++;
            if (outst > depth(sel)) begin
                errors++;
                $display("FAIL outstanding: got %0d allowed at most %0d", outst, depth(sel));
            end
        end
        if (pvalid[sel] && stall_prev) chk("stable_while_stalled", 64'(cur), 64'(held));
        if (pvalid[sel] && first_v < 0) first_v = rel;
        if (hs) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_pixel: got pixel %0h expected none", cur);
            end else begin
                e = q.pop_front();
                chk($sformatf("pixel #%0d", npix), 64'(cur), 64'(e));
            end
            npix++;
            if (peof[sel]) last_hs = rel;
        end
        if (done[sel] || prev_eof_hs) chk("done_after_eof", 64'(done[sel]), 64'(prev_eof_hs));
        if (done[sel]) begin
            ndone++;
            chk("busy_low_at_done", 64'(busy[sel]), 64'd0);
        end
        if (rel == 1) chk("busy_after_start", 64'(busy[sel]), 64'd1);
        prev_eof_hs = hs & peof[sel];
        stall_prev  = pvalid[sel] & ~pix_ready;
        held        = cur;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int vi, input vec_t v);
        int   budget, post, n, w, addr;
        exp_t e;
        logic [7:0] d;
        sel = v.sel;
        n   = img_n(sel);
        w   = img_w(sel);
        q.delete();
        for (int i = 0; i < n; i++) begin
            addr  = base_of(sel) + i;
            d     = ram_f(10'(addr));
            e.data = (sel == 0) ? {7'd0, ^d} : d;
            e.sof  = (i == 0);
            e.eol  = (i % w == w - 1);
            e.eof  = (i == n - 1);
            q.push_back(e);
        end
        npix = 0; ndone = 0; first_v = -1; last_hs = -1; outst = 0; acnt = 0;
        stall_prev = 1'b0; prev_eof_hs = 1'b0;
        budget = n * 5 + 200;
        post   = -1;
        rel    = 0;
        start     = 1'b1;
        pix_ready = (int'($urandom_range(99)) < v.pct);
        forever begin
            tick();
            rel++;
            if (v.abort_at > 0 && npix == v.abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                tick();
                chk_reset(sel, $sformatf("v%0d mid_frame", vi));
                reset = 1'b0;
                break;
            end
            if (ndone > 0 && post < 0) post = rel + 6;
            if (post >= 0 && rel >= post) break;
            if (rel >= budget) begin
                checks++;
                errors++;
                $display("FAIL v%0d timeout: got %0d pixels %0d done after %0d cycles", vi, npix, ndone, rel);
                break;
            end
            start     = (rel == v.restart_at);
            pix_ready = (int'($urandom_range(99)) < v.pct);
        end
        start = 1'b0;
        chk($sformatf("v%0d pixel_count", vi), 64'(npix), 64'(v.exp_pix));
        chk($sformatf("v%0d done_count", vi), 64'(ndone), 64'(v.exp_done));
        chk($sformatf("v%0d first_valid_cycle", vi), 64'(first_v), 64'(v.exp_first));
        if (v.exp_last >= 0) chk($sformatf("v%0d last_pixel_cycle", vi), 64'(last_hs), 64'(v.exp_last));
        if (v.abort_at == 0) chk($sformatf("v%0d leftover_expected", vi), 64'(q.size()), 64'd0);
    endtask

    initial begin
        // sel, ready%, restart_at, abort_at, pixels, dones, first valid, last pixel cycle
        tbl[0] = '{0, 100, -1,   0, 784, 1, 3, 786};
        tbl[1] = '{1, 100, -1,   0,  12, 1, 5,  16};
        tbl[2] = '{2, 100, -1,   0,  12, 1, 4,  15};
        tbl[3] = '{1,  30, -1,   0,  12, 1, 5,  -1};
        tbl[4] = '{2,  30, -1,   0,  12, 1, 4,  -1};
        tbl[5] = '{0, 100, 200,  0, 784, 1, 3, 786};
        tbl[6] = '{0,  60, -1,   0, 784, 1, 3,  -1};
        tbl[7] = '{0, 100, -1, 300, 300, 0, 3,  -1};
        tbl[8] = '{0, 100, -1,   0, 784, 1, 3, 786};

        reset = 1'b1; start = 1'b0; pix_ready = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk_reset(s, "power_on");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run(i, tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
